filter_out_packer: RTL and testbench
====================================

# filter_out_packer

Downstream companion of the image-processing filter stages (sobel and siblings). Consumes the filter's per-pixel write strobe and 8-bit R/G/B result, packs four pixels per 128-bit word as xRGB, tracks line/frame position, and buffers packed words in an internal FIFO toward the memory-write side through a valid/ready handshake. The filter cannot stall, so the block absorbs bursts, pads short line tails, and flags overflow instead of back-pressuring.

## Interface

Parameters:
- H_ACTIVE, 1920: pixels per line (≥1).
- V_ACTIVE, 1080: lines per frame (≥1).
- FIFO_DEPTH, 16: word FIFO depth; must be a power of 2, ≥2.

Ports:
- CLK  in  1  single clock.
- RST  in  1  reset, asynchronous, active-high.
- SOF  in  1  start-of-frame pulse; resynchronises counters.
- WREN  in  1  pixel valid from the filter, one pixel per asserted cycle.
- IN_R / IN_G / IN_B  in  8 each  pixel components.
- OUT_DATA  out  128  packed word; pixel k in bits [32k+31:32k] = {8'h00,R,G,B}.
- OUT_VALID  out  1  FIFO head valid.
- OUT_READY  in  1  consumer accepts head when OUT_VALID & OUT_READY.
- OUT_LAST  out  1  head word is the last word of a line.
- OUT_FLAST  out  1  head word is the last word of the frame.
- FRAME_DONE  out  1  one-cycle pulse after the frame-last word is accepted.
- OVERFLOW  out  1  sticky: a packed word was dropped.
- LEVEL  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation

- Counters: x in 0..H_ACTIVE-1, y in 0..V_ACTIVE-1, slot in 0..3. Each WREN advances x; at x=H_ACTIVE-1, x wraps to 0 and y increments; at the last pixel of the frame y wraps to 0.
- Packing: pixel goes to lane `slot`. A word is pushed when slot=3 or x=H_ACTIVE-1. On a line-end push, unfilled lanes are 0, slot resets to 0, LAST=1, and FLAST=1 if y=V_ACTIVE-1. Push data combines the registered lanes with the current pixel; no extra cycle.
- FIFO entries are {FLAST, LAST, data[127:0]}. Head is registered (not fall-through).
- Push while full with no pop in the same cycle: the word is dropped, OVERFLOW←1. The counters still advance. Push and pop in the same cycle while full: both take effect, and there is no overflow.
- SOF: clears x, y, slot and the lane registers, and clears OVERFLOW. A WREN in the same cycle is pixel (0,0) of the new frame. SOF does not flush the FIFO.
- A partial word pending at SOF is discarded.
- FRAME_DONE: registered. High for exactly one cycle, the cycle after a handshake on a FLAST word.
- Dataflow has no state machine beyond the counters. Overflow is a sticky flag with two states, CLEAN and OVF:
  - CLEAN→OVF on a drop.
  - OVF→CLEAN only on RST or SOF.

## Timing

- Reset values: OUT_DATA=0, OUT_VALID=0, OUT_LAST=0, OUT_FLAST=0, FRAME_DONE=0, OVERFLOW=0, LEVEL=0. Counters, lanes and FIFO pointers are all 0.
- Asynchronous reset mid-line: all state clears immediately; partial words and FIFO contents are lost.
- Latency: push at edge n gives OUT_VALID=1 in cycle n+1 if the FIFO was empty. LEVEL updates at the push/pop edge.
- OUT_DATA, OUT_LAST and OUT_FLAST are stable while OUT_VALID=1 and OUT_READY=0.
- Sustained WREN every cycle gives one push per 4 cycles; OUT_READY≥25% duty never overflows.
- Back-to-back line ends with H_ACTIVE≤4 push every line-end cycle.

## Test plan

Use H_ACTIVE=6, V_ACTIVE=2, FIFO_DEPTH=4 unless stated.

- Reset: assert RST asynchronously mid-clock -> all outputs 0 at once; after release OUT_VALID stays 0 with WREN=0.
- Packing, OUT_READY=1: WREN 4 cycles with RGB (01,02,03),(04,05,06),(07,08,09),(0A,0B,0C) -> the cycle after the 4th edge OUT_VALID=1, OUT_DATA=0x000A0B0C_00070809_00040506_00010203, OUT_LAST=0.
- Line tail: continue with pixels (11,12,13),(14,15,16) -> OUT_DATA=0x00000000_00000000_00141516_00111213, OUT_LAST=1, OUT_FLAST=0. The next line's first word starts at lane 0.
- Full frame, OUT_READY=1: 12 WREN pixels -> 4 words with LAST on words 2 and 4 and FLAST only on word 4. FRAME_DONE is high exactly one cycle, after the word-4 handshake.
- Overflow: H_ACTIVE=16, OUT_READY=0, 20 WREN -> LEVEL=4, OVERFLOW=1, 5th word dropped, first 4 words intact. Then OUT_READY=1 drains 4 words, and OVERFLOW stays 1 until SOF.
- Full plus simultaneous pop: LEVEL=4, push and pop in the same cycle -> LEVEL stays 4, OVERFLOW=0.
- SOF mid-line: SOF with a concurrent WREN after 2 pixels -> that pixel lands in lane 0, x=1 next. Old FIFO words still drain in order.

Source files
------------

// File: rtl/filter_out_packer_if.sv
// Packed-word stream from filter_out_packer toward the memory-write side.
// The master drives data plus line/frame markers; the slave accepts the head with ready.
interface filter_out_packer_if;
    logic [127:0] data;
    logic         valid;
    logic         ready;
    logic         last;
    logic         flast;

    modport master (output data, output valid, output last, output flast, input ready);
    modport slave  (input data, input valid, input last, input flast, output ready);
endinterface

// File: rtl/filter_out_packer.sv
// Packs filter pixels four per 128-bit xRGB word, tracks line/frame position and
// buffers words in a small FIFO; drops (and flags) words instead of stalling the filter.
module filter_out_packer #(
    parameter int H_ACTIVE   = 1920,
    parameter int V_ACTIVE   = 1080,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sof,
    input  logic                          wren,
    input  logic [7:0]                    in_r,
    input  logic [7:0]                    in_g,
    input  logic [7:0]                    in_b,
    filter_out_packer_if.master           word_bus,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        CLEAN,
        OVF
    } ovf_state_t;

    logic [XW-1:0]  x, cur_x;
    logic [YW-1:0]  y, cur_y;
    logic [1:0]     slot, cur_slot;
    logic [31:0]    lane0, lane1, lane2;
    logic [31:0]    pixel;
    logic           x_last, y_last;
    logic           push;
    logic [127:0]   push_word;

    logic [129:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic [129:0]   head;
    logic           full, pop, wr_en, drop;

    ovf_state_t     ovf_state, ovf_next;

    // SOF makes the current pixel (0,0) of the new frame, so position is muxed before use.
    always_comb begin
        cur_x    = sof ? '0 : x;
        cur_y    = sof ? '0 : y;
        cur_slot = sof ? 2'd0 : slot;
        pixel    = {8'h00, in_r, in_g, in_b};
        x_last   = (cur_x == XW'(H_ACTIVE - 1));
        y_last   = (cur_y == YW'(V_ACTIVE - 1));
        push     = wren && ((cur_slot == 2'd3) || x_last);
    end

    always_comb begin
        push_word = '0;
        case (cur_slot)
            2'd0:    push_word[31:0] = pixel;
            2'd1:    push_word[63:0] = {pixel, lane0};
            2'd2:    push_word[95:0] = {pixel, lane1, lane0};
            default: push_word       = {pixel, lane2, lane1, lane0};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x     <= '0;
            y     <= '0;
            slot  <= 2'd0;
            lane0 <= '0;
            lane1 <= '0;
            lane2 <= '0;
        end else begin
            if (sof) begin
                x     <= '0;
                y     <= '0;
                slot  <= 2'd0;
                lane0 <= '0;
                lane1 <= '0;
                lane2 <= '0;
            end
            if (wren) begin
                if (x_last) begin
                    x    <= '0;
                    slot <= 2'd0;
                    y    <= y_last ? '0 : cur_y + 1'b1;
                end else begin
                    x    <= cur_x + 1'b1;
                    slot <= cur_slot + 2'd1;
                    case (cur_slot)
                        2'd0:    lane0 <= pixel;
                        2'd1:    lane1 <= pixel;
                        2'd2:    lane2 <= pixel;
                        default: ;
                    endcase
                end
            end
        end
    end

    // A write into a full FIFO is legal when the head leaves in the same cycle.
    always_comb begin
        head  = mem[rd_ptr];
        full  = (count == (AW+1)'(FIFO_DEPTH));
        pop   = (count != '0) && word_bus.ready;
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= {push && x_last && y_last, push && x_last, push_word};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            frame_done <= pop && head[129];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_state <= CLEAN;
        else     ovf_state <= ovf_next;
    end

    always_comb begin
        ovf_next = ovf_state;
        case (ovf_state)
            CLEAN:   if (drop) ovf_next = OVF;
            OVF:     if (sof && !drop) ovf_next = CLEAN;
            default: ovf_next = CLEAN;
        endcase
    end

    assign word_bus.data  = head[127:0];
    assign word_bus.last  = head[128];
    assign word_bus.flast = head[129];
    assign word_bus.valid = (count != '0);
    assign overflow       = (ovf_state == OVF);
    assign level          = count;

endmodule

// File: tb/tb_filter_out_packer.sv
// Directed bench: a per-cycle vector table for packing/line/frame behaviour plus
// hand sequences for async reset, overflow, full-with-pop and mid-line SOF.
module tb_filter_out_packer;

    logic       clk;
    logic       rst;
    logic       sof;
    logic       wren;
    logic [7:0] in_r, in_g, in_b;

    logic       frame_done_a, overflow_a;
    logic [2:0] level_a;
    logic       frame_done_b, overflow_b;
    logic [2:0] level_b;

    int n_compared;
    int n_mismatched;

    filter_out_packer_if bus_a ();
    filter_out_packer_if bus_b ();

    filter_out_packer #(.H_ACTIVE(6), .V_ACTIVE(2), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .sof(sof), .wren(wren),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .word_bus(bus_a),
        .frame_done(frame_done_a), .overflow(overflow_a), .level(level_a)
    );

    filter_out_packer #(.H_ACTIVE(16), .V_ACTIVE(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .sof(sof), .wren(wren),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .word_bus(bus_b),
        .frame_done(frame_done_b), .overflow(overflow_b), .level(level_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         wren;
        logic [23:0]  rgb;
        logic         exp_valid;
        logic         exp_last;
        logic         exp_flast;
        logic         exp_fdone;
        logic [2:0]   exp_level;
        logic [127:0] exp_data;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [23:0] pix(input int i);
        logic [7:0] v;
        v = 8'(i);
        return {v, v + 8'h40, v + 8'h80};
    endfunction

    function automatic logic [127:0] word4(input int base);
        return {8'h00, pix(base + 3), 8'h00, pix(base + 2), 8'h00, pix(base + 1), 8'h00, pix(base)};
    endfunction

    task automatic apply_stimulus(input logic en, input logic [23:0] rgb);
        wren = en;
        {in_r, in_g, in_b} = rgb;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst  = 1'b1;
        sof  = 1'b0;
        wren = 1'b0;
        {in_r, in_g, in_b} = 24'h0;
        bus_a.ready = 1'b1;
        bus_b.ready = 1'b0;

        vecs[0]  = '{1'b1, 24'h010203, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 128'h0};
        vecs[1]  = '{1'b1, 24'h040506, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 128'h0};
        vecs[2]  = '{1'b1, 24'h070809, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 128'h0};
        vecs[3]  = '{1'b1, 24'h0A0B0C, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1,
                     128'h000A0B0C_00070809_00040506_00010203};
        vecs[4]  = '{1'b1, 24'h111213, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 128'h0};
        vecs[5]  = '{1'b1, 24'h141516, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1,
                     128'h00000000_00000000_00141516_00111213};
        vecs[6]  = '{1'b1, 24'h212223, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 128'h0};
        vecs[7]  = '{1'b1, 24'h242526, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 128'h0};
        vecs[8]  = '{1'b1, 24'h272829, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 128'h0};
        vecs[9]  = '{1'b1, 24'h2A2B2C, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1,
                     128'h002A2B2C_00272829_00242526_00212223};
        vecs[10] = '{1'b1, 24'h313233, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 128'h0};
        vecs[11] = '{1'b1, 24'h343536, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1,
                     128'h00000000_00000000_00343536_00313233};
        vecs[12] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 128'h0};
        vecs[13] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 128'h0};

        repeat (3) @(posedge clk);
        #1;
        check_output("reset valid", 128'(bus_a.valid), 128'd0);
        check_output("reset data", bus_a.data, 128'd0);
        check_output("reset last", 128'(bus_a.last), 128'd0);
        check_output("reset flast", 128'(bus_a.flast), 128'd0);
        check_output("reset frame_done", 128'(frame_done_a), 128'd0);
        check_output("reset overflow", 128'(overflow_a), 128'd0);
        check_output("reset level", 128'(level_a), 128'd0);
        rst = 1'b0;
        apply_stimulus(1'b0, 24'h0);

        // Packing, line tail and a full two-line frame with the consumer always ready.
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i].wren, vecs[i].rgb);
            check_output($sformatf("vec%0d valid", i), 128'(bus_a.valid), 128'(vecs[i].exp_valid));
            check_output($sformatf("vec%0d level", i), 128'(level_a), 128'(vecs[i].exp_level));
            check_output($sformatf("vec%0d frame_done", i), 128'(frame_done_a), 128'(vecs[i].exp_fdone));
            if (vecs[i].exp_valid) begin
                check_output($sformatf("vec%0d data", i), bus_a.data, vecs[i].exp_data);
                check_output($sformatf("vec%0d last", i), 128'(bus_a.last), 128'(vecs[i].exp_last));
                check_output($sformatf("vec%0d flast", i), 128'(bus_a.flast), 128'(vecs[i].exp_flast));
            end
        end

        // Asynchronous reset in the middle of a clock cycle with a word waiting.
        bus_a.ready = 1'b0;
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, pix(i));
        wren = 1'b0;
        check_output("pre-reset valid", 128'(bus_a.valid), 128'd1);
        #3;
        rst = 1'b1;
        #1;
        check_output("async reset valid", 128'(bus_a.valid), 128'd0);
        check_output("async reset level", 128'(level_a), 128'd0);
        check_output("async reset data", bus_a.data, 128'd0);
        #2;
        rst = 1'b0;
        apply_stimulus(1'b0, 24'h0);
        apply_stimulus(1'b0, 24'h0);
        check_output("post-reset idle valid", 128'(bus_a.valid), 128'd0);

        // Overflow on the 16-pixel-line instance: the fifth word is dropped.
        bus_b.ready = 1'b0;
        for (int i = 0; i < 20; i++) apply_stimulus(1'b1, pix(i));
        apply_stimulus(1'b0, 24'h0);
        check_output("ovf level", 128'(level_b), 128'd4);
        check_output("ovf flag", 128'(overflow_b), 128'd1);
        bus_b.ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check_output($sformatf("ovf drain%0d data", j), bus_b.data, word4(4 * j));
            check_output($sformatf("ovf drain%0d last", j), 128'(bus_b.last), 128'(j == 3));
            apply_stimulus(1'b0, 24'h0);
        end
        bus_b.ready = 1'b0;
        check_output("ovf drained valid", 128'(bus_b.valid), 128'd0);
        check_output("ovf sticky", 128'(overflow_b), 128'd1);
        sof = 1'b1;
        apply_stimulus(1'b0, 24'h0);
        sof = 1'b0;
        check_output("ovf cleared by sof", 128'(overflow_b), 128'd0);

        // Full FIFO with a push and a pop landing on the same edge.
        for (int i = 0; i < 19; i++) apply_stimulus(1'b1, pix(i));
        check_output("full level", 128'(level_b), 128'd4);
        bus_b.ready = 1'b1;
        apply_stimulus(1'b1, pix(19));
        bus_b.ready = 1'b0;
        wren = 1'b0;
        check_output("push+pop level", 128'(level_b), 128'd4);
        check_output("push+pop overflow", 128'(overflow_b), 128'd0);
        check_output("push+pop head", bus_b.data, word4(4));

        // SOF mid-line with a concurrent pixel; older words still drain in order.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        apply_stimulus(1'b0, 24'h0);
        bus_a.ready = 1'b0;
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, pix(i));
        sof = 1'b1;
        apply_stimulus(1'b1, pix(8));
        sof = 1'b0;
        for (int i = 9; i < 12; i++) apply_stimulus(1'b1, pix(i));
        wren = 1'b0;
        check_output("sof level", 128'(level_a), 128'd3);
        bus_a.ready = 1'b1;
        check_output("sof w1 data", bus_a.data, word4(0));
        check_output("sof w1 last", 128'(bus_a.last), 128'd0);
        apply_stimulus(1'b0, 24'h0);
        check_output("sof w2 data", bus_a.data, {64'h0, 8'h00, pix(5), 8'h00, pix(4)});
        check_output("sof w2 last", 128'(bus_a.last), 128'd1);
        apply_stimulus(1'b0, 24'h0);
        check_output("sof w3 data", bus_a.data, word4(8));
        check_output("sof w3 last", 128'(bus_a.last), 128'd0);
        apply_stimulus(1'b0, 24'h0);
        check_output("sof drained valid", 128'(bus_a.valid), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
